// File: rtl/net_resolver.sv
// Registered resolver for one multi-driver net, in the style of the HDL net kinds.
// Each bit is carried as two planes (xz, val): 00=0, 01=1, 10=Z, 11=X.
module net_resolver #(
  parameter int WIDTH        = 4,
  parameter int NUM_DRIVERS  = 4,
  parameter int MODE         = 0,
  parameter int DECAY_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_DRIVERS*WIDTH-1:0] drv_val,
  input  logic [NUM_DRIVERS-1:0]       drv_en,
  input  logic                         clr_cnt,
  output logic [WIDTH-1:0]             res_val,
  output logic [WIDTH-1:0]             res_xz,
  output logic                         conflict,
  output logic [7:0]                   conflict_cnt,
  output logic                         charged
);

  localparam int MODE_WAND   = 1;
  localparam int MODE_WOR    = 2;
  localparam int MODE_TRI0   = 3;
  localparam int MODE_TRI1   = 4;
  localparam int MODE_TRIREG = 5;

  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

  // Reset/idle value per net kind: tri/wand/wor float, tri0/tri1 pull, trireg starts unknown.
  localparam logic [WIDTH-1:0] RST_XZ  = (MODE == MODE_TRI0 || MODE == MODE_TRI1) ? ALL_ZEROS : ALL_ONES;
  localparam logic [WIDTH-1:0] RST_VAL = (MODE == MODE_TRI1 || MODE == MODE_TRIREG) ? ALL_ONES : ALL_ZEROS;

  localparam int CW = (DECAY_CYCLES < 2) ? 1 : $clog2(DECAY_CYCLES + 1);
  localparam logic [CW-1:0] DECAY_MAX = CW'(DECAY_CYCLES);

  logic [WIDTH-1:0] any_one;
  logic [WIDTH-1:0] any_zero;
  logic             any_en;

  // Per bit: does any enabled driver pull it high, and does any pull it low.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [NUM_DRIVERS-1:0] column;
    for (genvar gj = 0; gj < NUM_DRIVERS; gj++) begin : g_drv
      assign column[gj] = drv_val[gj*WIDTH + gi];
    end
    assign any_one[gi]  = |(column & drv_en);
    assign any_zero[gi] = |(~column & drv_en);
  end

  assign any_en = |drv_en;

  logic [WIDTH-1:0] res_val_reg, res_val_next;
  logic [WIDTH-1:0] res_xz_reg, res_xz_next;
  logic             conflict_reg, conflict_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             charged_reg, charged_next;
  logic [CW-1:0]    decay_reg, decay_next;
  logic [CW-1:0]    decay_inc;

  assign decay_inc = decay_reg + 1'b1;

  always_comb begin
    res_val_next  = res_val_reg;
    res_xz_next   = res_xz_reg;
    conflict_next = 1'b0;
    charged_next  = 1'b0;
    decay_next    = '0;
    if (any_en) begin
      if (MODE == MODE_WAND) begin
        res_val_next = ~any_zero;
        res_xz_next  = ALL_ZEROS;
      end else if (MODE == MODE_WOR) begin
        res_val_next = any_one;
        res_xz_next  = ALL_ZEROS;
      end else begin
        // Disagreeing bits have any_one set, so val=1 lands them on the X code.
        res_val_next  = any_one;
        res_xz_next   = any_one & any_zero;
        conflict_next = |(any_one & any_zero);
      end
      charged_next = (MODE == MODE_TRIREG);
    end else if (MODE == MODE_TRIREG) begin
      charged_next = charged_reg;
      decay_next   = decay_reg;
      if (DECAY_CYCLES != 0 && decay_reg != DECAY_MAX) begin
        decay_next = decay_inc;
        if (decay_inc == DECAY_MAX) begin
          res_val_next = ALL_ONES;
          res_xz_next  = ALL_ONES;
          charged_next = 1'b0;
        end
      end
    end else begin
      res_val_next = RST_VAL;
      res_xz_next  = RST_XZ;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (clr_cnt)
      cnt_next = 8'd0;
    else if (conflict_next && cnt_reg != 8'hFF)
      cnt_next = cnt_reg + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_val_reg  <= RST_VAL;
      res_xz_reg   <= RST_XZ;
      conflict_reg <= 1'b0;
      cnt_reg      <= 8'd0;
      charged_reg  <= 1'b0;
      decay_reg    <= '0;
    end else begin
      res_val_reg  <= res_val_next;
      res_xz_reg   <= res_xz_next;
      conflict_reg <= conflict_next;
      cnt_reg      <= cnt_next;
      charged_reg  <= charged_next;
      decay_reg    <= decay_next;
    end
  end

  assign res_val      = res_val_reg;
  assign res_xz       = res_xz_reg;
  assign conflict     = conflict_reg;
  assign conflict_cnt = cnt_reg;
  assign charged      = charged_reg;

endmodule

// File: doc/net_resolver.md
NET_RESOLVER -- requirements
Module: net_resolver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bits per net.
REQ-002 SHALL have parameter NUM_DRIVERS, default 4, meaning number of drivers per net (range 1..16).
REQ-003 SHALL have parameter MODE, default 0, meaning net kind: 0=tri, 1=wand, 2=wor, 3=tri0, 4=tri1, 5=trireg.
REQ-004 SHALL have parameter DECAY_CYCLES, default 8, meaning trireg charge lifetime in cycles; 0 means the charge never decays.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port drv_val, input, NUM_DRIVERS*WIDTH bits: driver i value in slice [i*WIDTH +: WIDTH].
REQ-008 SHALL have port drv_en, input, NUM_DRIVERS bits: bit i=1 means driver i actively drives all WIDTH bits.
REQ-009 SHALL have port clr_cnt, input, 1 bit: synchronous clear of conflict_cnt.
REQ-010 SHALL have port res_val, output, WIDTH bits: resolved value plane.
REQ-011 SHALL have port res_xz, output, WIDTH bits: per-bit unknown plane; encoding (xz,val) is 00=0, 01=1, 10=Z, 11=X.
REQ-012 SHALL have port conflict, output, 1 bit: registered flag, high when any bit resolved to X through driver contention.
REQ-013 SHALL have port conflict_cnt, output, 8 bits: saturating count of conflict cycles.
REQ-014 SHALL have port charged, output, 1 bit: trireg only; high while holding undecayed stored charge; always 0 for other modes.

Function
REQ-015 All outputs SHALL be registered, with resolution of the current drv_val/drv_en visible one clk edge later (latency 1).
REQ-016 With any driver enabled, MODE 0, 3, 4 and 5 SHALL resolve each bit to the common value if all enabled drivers agree, and to X (11) otherwise.
REQ-017 MODE 1 (wand) SHALL resolve each bit to 0 if any enabled driver drives 0, and to 1 otherwise; it SHALL never produce X.
REQ-018 MODE 2 (wor) SHALL resolve each bit to 1 if any enabled driver drives 1, and to 0 otherwise; it SHALL never produce X.
REQ-019 With drv_en all zero, output SHALL be Z in MODE 0/1/2, all-0 in MODE 3, and all-1 in MODE 4.
REQ-020 In MODE 5 with drv_en all zero, output SHALL hold the last driven resolved value, X bits included.
REQ-021 In MODE 5, the decay counter SHALL reset to 0 on any cycle with a driver enabled and increment each undriven cycle.
REQ-022 In MODE 5, when the decay counter reaches DECAY_CYCLES (if nonzero), output SHALL become all-X and charged SHALL drop, both on that same edge.
REQ-023 In MODE 5, the decay counter SHALL saturate and not wrap, and the output SHALL remain X until a driver is re-enabled.
REQ-024 charged SHALL be 1 after any driven cycle in MODE 5, and SHALL remain 1 while undriven and undecayed.
REQ-025 conflict SHALL be 1 in a cycle where at least one bit resolved X by contention per REQ-016; decay-X and reset-X SHALL NOT set it.
REQ-026 conflict_cnt SHALL increment on each cycle conflict is registered high and saturate at 255.
REQ-027 clr_cnt SHALL clear conflict_cnt to 0, taking priority over a simultaneous increment.
REQ-028 With NUM_DRIVERS=1, contention SHALL be impossible and conflict SHALL stay 0.

Reset
REQ-029 While rst is high, res_xz/res_val SHALL be: all-Z (xz=1,val=0) in MODE 0/1/2; all-0 in MODE 3; all-1 in MODE 4; all-X in MODE 5.
REQ-030 While rst is high, conflict=0, conflict_cnt=0, charged=0 and the decay counter=0.
REQ-031 rst asserted mid-operation SHALL override immediately without waiting for clk.
REQ-032 The first edge after rst deasserts SHALL resolve normally.

Verification
REQ-033 MODE 0, W=4, N=2: en=11, vals 1010/1010 -> next cycle val=1010, xz=0000, conflict=0; vals 1010/1001 -> bits[1:0]=X (xz=0011), conflict=1, cnt=1.
REQ-034 MODE 1 and 2: en=11, vals 1100/1010 -> wand 1000, wor 1110, xz=0000; en=00 -> Z.
REQ-035 MODE 3/4: en=00 -> 0000 / 1111, xz=0000; one driver 0101 -> 0101.
REQ-036 MODE 5, DECAY_CYCLES=3: drive 0110, then release -> hold 0110 with charged=1 for 2 cycles, then X and charged=0 on 3rd undriven edge; re-drive 0001 -> 0001, charged=1.
REQ-037 Counter: 300 consecutive conflict cycles -> conflict_cnt=255; clr_cnt pulsed concurrently with a conflict -> 0.
REQ-038 Async reset: assert rst between clk edges during MODE 5 hold -> outputs all-X, charged=0 immediately.
